nz_pop_packer: RTL and testbench
================================

Name: nz_pop_packer

Overview:
- Upstream feeder of the 5-lane row memory.
- Accepts one activation word per cycle on a valid/ready stream and discards words whose keep flag is low (sparse skip).
- Packs kept words into groups of up to 5 and emits each group as one write burst: pop_num, addr, data_out_0..4.
- Pulses row_fini when an end-of-row group is emitted; write address advances by pop_num and restarts at 0 each row.

Parameters:
- WORD_WIDTH, 16, data word width.
- ADDR_WIDTH, 3, row-memory address width.
- RAM_DEPTH, 1<<ADDR_WIDTH, row-memory depth; write pointer wraps modulo this.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WORD_WIDTH  activation word.
- in_keep  input  1  1 = word is stored, 0 = word is skipped.
- in_last  input  1  word is the last of its row.
- mem_busy  input  1  downstream cannot take a burst this cycle.
- pop_num  output  3  words in the emitted burst (0..5); nonzero for exactly one cycle per burst.
- addr  output  ADDR_WIDTH  start address of the burst.
- data_out_0..data_out_4  output  WORD_WIDTH each  burst lanes; data_out_4 = oldest word, data_out_3 = next, and so on.
- row_fini  output  1  one-cycle pulse with the burst that closes a row.
- ovf  output  1  sticky flag: a row held more than RAM_DEPTH kept words.

Behaviour:
- Reset: all outputs 0; accumulator count 0; write pointer 0; state FILL; in_ready 0 while rst is high.
- Transfer occurs when in_valid && in_ready at a clock edge.
- States and transitions:
  - FILL: in_ready=1.
    - A transferred word with keep=1 goes to slot[cnt], then cnt++.
    - A group completes when cnt reaches 5, or when a transfer has in_last=1 (with or without keep).
    - On completion with mem_busy=0: burst registers load at that edge and appear cycle t+1 (latency 1 from the completing transfer); cnt clears; stay in FILL.
    - On completion with mem_busy=1: the group moves to the staging register; go to HOLD.
  - HOLD: in_ready=0. At the first edge with mem_busy=0, emit the staged group (outputs valid the next cycle), then return to FILL.
- Burst outputs:
  - pop_num = group count.
  - addr = write pointer before the burst.
  - Lanes not covered by pop_num are driven 0.
  - pop_num and row_fini return to 0 the following cycle; addr and data hold until the next burst.
- Pointer:
  - Non-last burst: ptr <= (ptr + pop_num) mod RAM_DEPTH.
  - Last burst: ptr <= 0.
- ovf: set when the running per-row kept count exceeds RAM_DEPTH; cleared only by rst.
- Empty row (in_last with no kept words): emit pop_num=0 with row_fini=1, addr = current pointer.
- in_last on the 5th kept word: a single burst with pop_num=5 and row_fini=1.
- Kept words with keep=0 still count as transfers but are not stored and do not advance the pointer.
- rst mid-HOLD: the staged group is discarded; no burst is emitted.

Optional Feature:
- Macro NZ_POP_ZERO_SKIP_EN.
- Defined: effective keep = in_keep && (in_data != 0), so zero words are dropped automatically.
- Undefined: effective keep = in_keep only.

Decomposition:
- Package nz_pop_pkg holds:
  - LANES = 5;
  - state enum {FILL, HOLD};
  - pop-count type (3 bits).
- One natural sub-module: nz_pop_lane_buf, the 5-slot accumulator plus staging register with its count logic.
- The FSM, pointer and ovf logic stay in the top level.

Test Plan:
- Reset mid-stream: assert rst while in HOLD -> pop_num=0, addr=0, in_ready=0 during reset, no burst after release.
- Five kept words A..E, last on E -> one cycle after E: pop_num=5, data_out_4=A, data_out_0=E, addr=0, row_fini=1; next cycle pop_num=0.
- Seven kept words, last on 7th -> burst1: pop_num=5, addr=0; burst2: pop_num=2, addr=5, row_fini=1, data_out_2..0=0; next row starts at addr=0.
- Row of keep=0 words ending in_last -> pop_num=0, row_fini=1, addr=0.
- mem_busy=1 when a group of 5 completes -> in_ready=0 in HOLD; drop mem_busy -> burst appears next cycle with the correct data; in_ready=1 again.
- Twelve kept words in one row -> addr sequence 0, 5, 2 (wrap mod 8); ovf=1 and stays set until rst.
- With NZ_POP_ZERO_SKIP_EN: in_keep=1, in_data=0 -> word dropped (cnt unchanged).

Source files
------------

// File: rtl/nz_pop_pkg.sv
// Shared types for the sparse activation packer: lane count, pop-count type, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nz_pop_pkg;

  // Number of row-memory lanes filled by one write burst.
  localparam int LANES = 5;

  // Words in one burst, 0..5.
  typedef logic [2:0] pop_cnt_t;

  localparam pop_cnt_t FULL_CNT = 3'd5;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/nz_pop_packer_if.sv
// Stream-in / burst-out bundle of the packer (in_* word stream, mem_busy, burst fields, ovf).
// Latency: n/a (wiring only).
// Backpressure: in_ready from the packer, mem_busy from the row memory.
// Ports: master = word source and row-memory side (the environment); slave = the packer.
interface nz_pop_packer_if #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  import nz_pop_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_keep;
  logic                  in_last;
  logic                  mem_busy;
  pop_cnt_t              pop_num;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] data_out_0;
  logic [WORD_WIDTH-1:0] data_out_1;
  logic [WORD_WIDTH-1:0] data_out_2;
  logic [WORD_WIDTH-1:0] data_out_3;
  logic [WORD_WIDTH-1:0] data_out_4;
  logic                  row_fini;
  logic                  ovf;

  modport master (
    output in_valid, in_data, in_keep, in_last, mem_busy,
    input  in_ready, pop_num, addr, data_out_0, data_out_1, data_out_2,
           data_out_3, data_out_4, row_fini, ovf
  );

  modport slave (
    input  in_valid, in_data, in_keep, in_last, mem_busy,
    output in_ready, pop_num, addr, data_out_0, data_out_1, data_out_2,
           data_out_3, data_out_4, row_fini, ovf
  );

endinterface

// File: rtl/nz_pop_lane_buf.sv
// Five-slot accumulator for kept words plus a one-group staging register.
// Latency: group contents available combinationally on the completing push; stage loads at that edge.
// Backpressure: none internally; caller only pushes while it can accept a word.
// Ports: push/keep/last/din = one transferred word; stage_en = park the completing group;
//        grp_* = group completing this cycle (lane LANES-1 = oldest); stage_* = parked group.
module nz_pop_lane_buf
  import nz_pop_pkg::*;
#(
  parameter int WORD_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             keep,
  input  logic                             last,
  input  logic [WORD_WIDTH-1:0]            din,
  input  logic                             stage_en,
  output logic                             grp_done,
  output pop_cnt_t                         grp_cnt,
  output logic [LANES-1:0][WORD_WIDTH-1:0] grp_lanes,
  output pop_cnt_t                         stage_cnt,
  output logic                             stage_last,
  output logic [LANES-1:0][WORD_WIDTH-1:0] stage_lanes
);

  logic [WORD_WIDTH-1:0] slot [LANES];
  pop_cnt_t              cnt;
  logic                  take;

  assign take = push && keep;

  // The completing word is folded in here so the group can leave on the same edge
  // it arrives, without first landing in a slot. Lanes past the count read as zero.
  always_comb begin
    grp_cnt   = cnt + pop_cnt_t'(take);
    grp_done  = push && (last || grp_cnt == FULL_CNT);
    grp_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      if (pop_cnt_t'(i) < cnt) begin
        grp_lanes[LANES-1-i] = slot[i];
      end else if (take && pop_cnt_t'(i) == cnt) begin
        grp_lanes[LANES-1-i] = din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      stage_cnt   <= '0;
      stage_last  <= 1'b0;
      stage_lanes <= '0;
      for (int i = 0; i < LANES; i++) begin
        slot[i] <= '0;
      end
    end else begin
      if (grp_done) begin
        cnt <= '0;
      end else if (take) begin
        slot[cnt] <= din;
        cnt       <= cnt + 3'd1;
      end
      if (stage_en) begin
        stage_cnt   <= grp_cnt;
        stage_last  <= last;
        stage_lanes <= grp_lanes;
      end
    end
  end

endmodule

// File: rtl/nz_pop_packer.sv
// Sparse-skip packer: drops unkept words, groups kept ones by 5 into row-memory write bursts.
// Latency: 1 cycle from the completing transfer to the burst (or from mem_busy falling while held).
// Backpressure: in_ready drops while a completed group waits in HOLD for mem_busy to clear.
// Ports: clk, rst (async, active-high); bus (slave side of nz_pop_packer_if).
// Build option: NZ_POP_ZERO_SKIP_EN also drops kept words whose data is zero.
module nz_pop_packer
  import nz_pop_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  nz_pop_packer_if.slave       bus
);

  localparam logic [ADDR_WIDTH:0] ROW_MAX = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  state_t                             state;
  logic                               xfer;
  logic                               keep_eff;
  logic                               grp_done;
  pop_cnt_t                           grp_cnt;
  logic [LANES-1:0][WORD_WIDTH-1:0]   grp_lanes;
  pop_cnt_t                           stage_cnt;
  logic                               stage_last;
  logic [LANES-1:0][WORD_WIDTH-1:0]   stage_lanes;
  logic                               fire;
  pop_cnt_t                           b_cnt;
  logic                               b_last;
  logic [LANES-1:0][WORD_WIDTH-1:0]   b_lanes;
  logic [ADDR_WIDTH-1:0]              ptr;
  logic [ADDR_WIDTH-1:0]              ptr_nxt;
  logic [ADDR_WIDTH:0]                row_kept;
  pop_cnt_t                           pop_q;
  logic [ADDR_WIDTH-1:0]              addr_q;
  logic [LANES-1:0][WORD_WIDTH-1:0]   lanes_q;
  logic                               fini_q;
  logic                               ovf_q;

  assign bus.in_ready = (state == FILL) && !rst;
  assign xfer         = bus.in_valid && bus.in_ready;

`ifdef NZ_POP_ZERO_SKIP_EN
  assign keep_eff = bus.in_keep && (bus.in_data != '0);
`else
  assign keep_eff = bus.in_keep;
`endif

  nz_pop_lane_buf #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_lane_buf (
    .clk         (clk),
    .rst         (rst),
    .push        (xfer),
    .keep        (keep_eff),
    .last        (bus.in_last),
    .din         (bus.in_data),
    .stage_en    (grp_done && bus.mem_busy),
    .grp_done    (grp_done),
    .grp_cnt     (grp_cnt),
    .grp_lanes   (grp_lanes),
    .stage_cnt   (stage_cnt),
    .stage_last  (stage_last),
    .stage_lanes (stage_lanes)
  );

  // Burst source: the staged group while held, otherwise the group completing now.
  always_comb begin
    fire    = (state == HOLD) ? !bus.mem_busy : (grp_done && !bus.mem_busy);
    b_cnt   = (state == HOLD) ? stage_cnt   : grp_cnt;
    b_last  = (state == HOLD) ? stage_last  : bus.in_last;
    b_lanes = (state == HOLD) ? stage_lanes : grp_lanes;
    ptr_nxt = b_last ? '0 : ADDR_WIDTH'((int'(ptr) + int'(b_cnt)) % RAM_DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      ptr      <= '0;
      row_kept <= '0;
      pop_q    <= '0;
      addr_q   <= '0;
      lanes_q  <= '0;
      fini_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      pop_q  <= '0;
      fini_q <= 1'b0;

      // Per-row kept count saturates at the depth; one more kept word is an overflow.
      if (xfer && keep_eff) begin
        if (row_kept == ROW_MAX) begin
          ovf_q <= 1'b1;
        end else begin
          row_kept <= row_kept + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
      end
      if (xfer && bus.in_last) begin
        row_kept <= '0;
      end

      case (state)
        FILL: if (grp_done && bus.mem_busy) state <= HOLD;
        HOLD: if (!bus.mem_busy) state <= FILL;
        default: state <= FILL;
      endcase

      if (fire) begin
        pop_q   <= b_cnt;
        addr_q  <= ptr;
        lanes_q <= b_lanes;
        fini_q  <= b_last;
        ptr     <= ptr_nxt;
      end
    end
  end

  assign bus.pop_num    = pop_q;
  assign bus.addr       = addr_q;
  assign bus.data_out_0 = lanes_q[0];
  assign bus.data_out_1 = lanes_q[1];
  assign bus.data_out_2 = lanes_q[2];
  assign bus.data_out_3 = lanes_q[3];
  assign bus.data_out_4 = lanes_q[4];
  assign bus.row_fini   = fini_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_nz_pop_packer.sv
// Bench for nz_pop_packer: rows of words are turned into expected bursts by a row-level model,
// queued, and compared by an independent monitor whenever the packer presents a burst.
module tb_nz_pop_packer;

  typedef struct packed {
    logic [2:0]  pop;
    logic [2:0]  addr;
    logic        fini;
    logic [79:0] lanes;
  } burst_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  nz_pop_packer_if #(.WORD_WIDTH(16), .ADDR_WIDTH(3)) bus ();

  nz_pop_packer #(.WORD_WIDTH(16), .ADDR_WIDTH(3), .RAM_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  burst_t      exp_q[$];
  logic [15:0] row_d[$];
  bit          row_k[$];
  bit          exp_ovf   = 1'b0;
  bit          rand_busy = 1'b0;
  bit          gaps      = 1'b0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic bit eff(input logic [15:0] d, input bit k);
`ifdef NZ_POP_ZERO_SKIP_EN
    return k && (d != 16'h0);
`else
    return k;
`endif
  endfunction

  // Row-level model: kept words are split into bursts of up to five; when the row's
  // last word is not itself kept, the row closes with a burst holding the remainder
  // (possibly empty). Addresses run from 0 modulo 8 within the row.
  task automatic model_row();
    logic [15:0] kept[$];
    int          n, nb, pos, a, c;
    bit          last_kept;
    burst_t      b;
    for (int i = 0; i < row_d.size(); i++) begin
      if (eff(row_d[i], row_k[i])) kept.push_back(row_d[i]);
    end
    n         = kept.size();
    last_kept = eff(row_d[row_d.size()-1], row_k[row_k.size()-1]);
    if (n > 8) exp_ovf = 1'b1;
    nb  = last_kept ? (n + 4) / 5 : n / 5 + 1;
    pos = 0;
    a   = 0;
    for (int k = 0; k < nb; k++) begin
      c       = (n - pos > 5) ? 5 : n - pos;
      b.pop   = 3'(c);
      b.addr  = 3'(a);
      b.fini  = (k == nb - 1);
      b.lanes = '0;
      for (int j = 0; j < c; j++) b.lanes[(4-j)*16 +: 16] = kept[pos+j];
      exp_q.push_back(b);
      pos += c;
      a    = (a + c) % 8;
    end
  endtask

  // Called at a negedge; returns at the negedge after the word was taken.
  task automatic send(input logic [15:0] d, input bit k, input bit l);
    int g = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_keep  = k;
    bus.in_last  = l;
    while (!bus.in_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL in_ready_timeout: in_ready=%0b after %0d cycles, want 1", bus.in_ready, g);
    end
    @(negedge clk);
  endtask

  task automatic drive_row();
    for (int i = 0; i < row_d.size(); i++) begin
      if (gaps && $urandom_range(0, 4) == 0) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      send(row_d[i], row_k[i], i == row_d.size() - 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic add(input logic [15:0] d, input bit k);
    row_d.push_back(d);
    row_k.push_back(k);
  endtask

  task automatic new_row();
    row_d.delete();
    row_k.delete();
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    chk("drain_pending", 80'(exp_q.size()), 80'd0);
  endtask

  // Monitor: every presented burst (pop_num != 0 or row_fini) pops one expectation.
  initial begin
    burst_t e;
    forever begin
      @(negedge clk);
      if (!rst && (bus.pop_num != 3'd0 || bus.row_fini)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_burst: pop_num=%0d addr=%0d row_fini=%0b, want no burst",
                   bus.pop_num, bus.addr, bus.row_fini);
        end else begin
          e = exp_q.pop_front();
          chk("pop_num", 80'(bus.pop_num), 80'(e.pop));
          chk("addr", 80'(bus.addr), 80'(e.addr));
          chk("row_fini", 80'(bus.row_fini), 80'(e.fini));
          chk("lanes", {bus.data_out_4, bus.data_out_3, bus.data_out_2, bus.data_out_1,
                        bus.data_out_0}, e.lanes);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_busy) bus.mem_busy = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_keep  = 1'b0;
    bus.in_last  = 1'b0;
    bus.mem_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 80'(bus.in_ready), 80'd0);
    chk("rst_pop_num", 80'(bus.pop_num), 80'd0);
    chk("rst_addr", 80'(bus.addr), 80'd0);
    chk("rst_row_fini", 80'(bus.row_fini), 80'd0);
    chk("rst_ovf", 80'(bus.ovf), 80'd0);
    chk("rst_data", {bus.data_out_4, bus.data_out_0}, 80'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 80'(bus.in_ready), 80'd1);

    // Five kept words A..E, last on E.
    new_row();
    for (int i = 0; i < 5; i++) add(16'hA0 + 16'(i), 1'b1);
    model_row();
    drive_row();
    drain();
    chk("pop_clears", 80'(bus.pop_num), 80'd0);

    // Seven kept words; then a row of only skipped words; then a lone zero word.
    new_row();
    for (int i = 0; i < 7; i++) add(16'h700 + 16'(i), 1'b1);
    model_row();
    drive_row();
    new_row();
    for (int i = 0; i < 3; i++) add(16'h55 + 16'(i), 1'b0);
    model_row();
    drive_row();
    new_row();
    add(16'h0, 1'b1);
    model_row();
    drive_row();
    drain();

    // Group of five completes while the memory is busy: held, then released.
    rand_busy    = 1'b0;
    bus.mem_busy = 1'b1;
    new_row();
    for (int i = 0; i < 6; i++) add(16'hB0 + 16'(i), 1'b1);
    model_row();
    for (int i = 0; i < 5; i++) send(row_d[i], 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    chk("hold_in_ready", 80'(bus.in_ready), 80'd0);
    repeat (3) @(negedge clk);
    chk("hold_in_ready_late", 80'(bus.in_ready), 80'd0);
    chk("hold_no_burst", 80'(bus.pop_num), 80'd0);
    bus.mem_busy = 1'b0;
    @(negedge clk);
    chk("release_in_ready", 80'(bus.in_ready), 80'd1);
    @(negedge clk);
    send(row_d[5], 1'b1, 1'b1);
    bus.in_valid = 1'b0;
    drain();

    // Twelve kept words: addresses 0, 5, 2 and the overflow flag.
    new_row();
    for (int i = 0; i < 12; i++) add(16'hC00 + 16'(i), 1'b1);
    model_row();
    drive_row();
    drain();
    chk("ovf_set", 80'(bus.ovf), 80'(exp_ovf));

    // Random rows with random memory stalls and input gaps.
    rand_busy = 1'b1;
    gaps      = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int len;
      len = $urandom_range(1, 14);
      new_row();
      for (int i = 0; i < len; i++) begin
        logic [15:0] d;
        d = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
        add(d, $urandom_range(0, 9) < 7);
      end
      model_row();
      drive_row();
    end
    drain();
    chk("ovf_sticky", 80'(bus.ovf), 80'(exp_ovf));

    // Reset while a group is held: nothing may come out afterwards.
    rand_busy    = 1'b0;
    gaps         = 1'b0;
    @(negedge clk);
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 5; i++) send(16'hD0 + 16'(i), 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    chk("rst_hold_in_ready_pre", 80'(bus.in_ready), 80'd0);
    rst = 1'b1;
    #1;
    chk("rst_hold_in_ready", 80'(bus.in_ready), 80'd0);
    chk("rst_hold_pop_num", 80'(bus.pop_num), 80'd0);
    chk("rst_hold_addr", 80'(bus.addr), 80'd0);
    chk("rst_hold_ovf", 80'(bus.ovf), 80'd0);
    bus.mem_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_in_ready", 80'(bus.in_ready), 80'd1);
    chk("post_rst_pop_num", 80'(bus.pop_num), 80'd0);
    chk("post_rst_queue", 80'(exp_q.size()), 80'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
